// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline hazard control for a 5-stage in-order core. A three-entry
//   scoreboard (EX, MEM, WB) tracks in-flight register writers. The
//   controller compares the ID stage's source registers against that
//   scoreboard and drives stall, flush, bubble and freeze controls in the
//   same cycle.
//
//   Priority of the control outputs: reset, then mem_busy (freeze), then
//   taken branch (flush), then RAW hazard (stall).
//
//   Optional feature macro: HAZARD_FORWARD_EN
//     defined   : only load-use on the EX slot stalls (one cycle).
//     undefined : any writer in EX or MEM stalls (up to two cycles).
//     In both builds WB never stalls, because the register file writes
//     through to the read ports.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   id_valid                 ID stage holds a real instruction
//   id_rs, id_rt             ID source register addresses
//   id_usesRs, id_usesRt     ID instruction reads rs / rt
//   id_registerWriteAddress  ID destination register
//   id_ifWriteRegsFile       ID instruction writes the register file
//   id_isLoad                ID instruction writes back memory data
//   ex_shouldJumpOrBranch    taken jump/branch resolved in EX
//   mem_busy                 data memory not ready; freeze the pipeline
//   pc_hold, ifid_hold       hold PC / IF-ID register
//   ifid_flush               clear IF-ID register
//   idex_bubble              insert a NOP into ID-EX
//   pipe_freeze              hold EX-MEM and MEM-WB registers
//   hz_state                 registered hazard class (RUN/RAW_STALL/FLUSH/MEM_WAIT)
//   stall_cycles             saturating count of cycles with pc_hold=1
module hazard_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_usesRs,
  input  logic        id_usesRt,
  input  logic [4:0]  id_registerWriteAddress,
  input  logic        id_ifWriteRegsFile,
  input  logic        id_isLoad,
  input  logic        ex_shouldJumpOrBranch,
  input  logic        mem_busy,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_freeze,
  output logic [1:0]  hz_state,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RAW_STALL = 2'd1,
    FLUSH     = 2'd2,
    MEM_WAIT  = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
    logic       is_load;
  } slot_t;

  hz_state_t state, state_next;
  slot_t     ex_slot, mem_slot, wb_slot, id_entry;
  logic      match_ex, raw;

  function automatic logic slot_match(input slot_t s,
                                      input logic use_rs, input logic [4:0] rs,
                                      input logic use_rt, input logic [4:0] rt);
    return s.valid && (s.addr != '0) &&
           ((use_rs && (rs == s.addr)) || (use_rt && (rt == s.addr)));
  endfunction

  // An instruction that is being replaced by a bubble must not enter the
  // scoreboard, otherwise a stalled reader would see itself as a writer.
  always_comb begin
    id_entry.valid   = id_valid && id_ifWriteRegsFile &&
                       (id_registerWriteAddress != '0) && !idex_bubble;
    id_entry.addr    = id_registerWriteAddress;
    id_entry.is_load = id_isLoad;
  end

  assign match_ex = slot_match(ex_slot, id_usesRs, id_rs, id_usesRt, id_rt);

`ifdef HAZARD_FORWARD_EN
  assign raw = id_valid && match_ex && ex_slot.is_load;
`else
  logic match_mem;
  assign match_mem = slot_match(mem_slot, id_usesRs, id_rs, id_usesRt, id_rt);
  assign raw = id_valid && (match_ex || match_mem);
`endif

  // WB is tracked so the scoreboard mirrors the pipeline, but it is never
  // consulted for hazards; which slot fields matter also depends on the build.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{ex_slot, mem_slot, wb_slot};

  // Next hazard class and control outputs, highest priority first.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    state_next  = RUN;
    if (rst) begin
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      pipe_freeze = 1'b1;
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      state_next  = MEM_WAIT;
    end else if (ex_shouldJumpOrBranch) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_next  = FLUSH;
    end else if (raw) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
      state_next  = RAW_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      ex_slot      <= '0;
      mem_slot     <= '0;
      wb_slot      <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_next;
      if (!pipe_freeze) begin
        wb_slot  <= mem_slot;
        mem_slot <= ex_slot;
        ex_slot  <= id_entry;
      end
      if (pc_hold && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign hz_state = state;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//   Directed, table-driven bench for hazard_controller. Each record holds
//   one cycle of inputs plus the expected combinational controls for that
//   cycle and the expected hz_state / stall_cycles after the clock edge.
//   The main table targets the default build; the HAZARD_FORWARD_EN build
//   uses its own short table instead.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt;
  logic        id_usesRs, id_usesRt;
  logic [4:0]  id_registerWriteAddress;
  logic        id_ifWriteRegsFile, id_isLoad;
  logic        ex_shouldJumpOrBranch, mem_busy;
  logic        pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze;
  logic [1:0]  hz_state;
  logic [31:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_controller dut (
    .clk                     (clk),
    .rst                     (rst),
    .id_valid                (id_valid),
    .id_rs                   (id_rs),
    .id_rt                   (id_rt),
    .id_usesRs               (id_usesRs),
    .id_usesRt               (id_usesRt),
    .id_registerWriteAddress (id_registerWriteAddress),
    .id_ifWriteRegsFile      (id_ifWriteRegsFile),
    .id_isLoad               (id_isLoad),
    .ex_shouldJumpOrBranch   (ex_shouldJumpOrBranch),
    .mem_busy                (mem_busy),
    .pc_hold                 (pc_hold),
    .ifid_hold               (ifid_hold),
    .ifid_flush              (ifid_flush),
    .idex_bubble             (idex_bubble),
    .pipe_freeze             (pipe_freeze),
    .hz_state                (hz_state),
    .stall_cycles            (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        r;
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        urs;
    logic        urt;
    logic [4:0]  wa;
    logic        we;
    logic        ld;
    logic        br;
    logic        mb;
    logic        e_pc;
    logic        e_fl;
    logic        e_bub;
    logic        e_frz;
    logic [1:0]  e_st;
    logic [31:0] e_sc;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic [4:0] rs, logic [4:0] rt,
                              logic urs, logic urt, logic [4:0] wa, logic we,
                              logic ld, logic br, logic mb,
                              logic e_pc, logic e_fl, logic e_bub, logic e_frz,
                              logic [1:0] e_st, logic [31:0] e_sc);
    vec_t t;
    t.r = r; t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
    t.wa = wa; t.we = we; t.ld = ld; t.br = br; t.mb = mb;
    t.e_pc = e_pc; t.e_fl = e_fl; t.e_bub = e_bub; t.e_frz = e_frz;
    t.e_st = e_st; t.e_sc = e_sc;
    return t;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle, check comb controls mid-cycle, then registered state
  // just after the rising edge.
  task automatic apply(input vec_t t, input int idx);
    rst                     = t.r;
    id_valid                = t.v;
    id_rs                   = t.rs;
    id_rt                   = t.rt;
    id_usesRs               = t.urs;
    id_usesRt               = t.urt;
    id_registerWriteAddress = t.wa;
    id_ifWriteRegsFile      = t.we;
    id_isLoad               = t.ld;
    ex_shouldJumpOrBranch   = t.br;
    mem_busy                = t.mb;
    #2;
    chk("pc_hold",     idx, {31'd0, pc_hold},     {31'd0, t.e_pc});
    chk("ifid_hold",   idx, {31'd0, ifid_hold},   {31'd0, t.e_pc});
    chk("ifid_flush",  idx, {31'd0, ifid_flush},  {31'd0, t.e_fl});
    chk("idex_bubble", idx, {31'd0, idex_bubble}, {31'd0, t.e_bub});
    chk("pipe_freeze", idx, {31'd0, pipe_freeze}, {31'd0, t.e_frz});
    @(posedge clk);
    #1;
    chk("hz_state",     idx, {30'd0, hz_state}, {30'd0, t.e_st});
    chk("stall_cycles", idx, stall_cycles,      t.e_sc);
  endtask

  task automatic run(input vec_t q[$], input int base);
    for (int i = 0; i < q.size(); i++) apply(q[i], base + i);
  endtask

  // Reset cycle: idle ID, expect bubble only, then RUN / 0 after the edge.
  function automatic vec_t rst_vec();
    return mk(1, 0,0,0,0,0,0,0,0,0,0, 0,0,1,0, 2'd0, 32'd0);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t seq[$];

    // Main table (default: EX and MEM writers both stall).
    //        r v rs rt urs urt wa we ld br mb   pc fl bub frz  st  sc
`ifndef HAZARD_FORWARD_EN
    tbl.push_back(rst_vec());
    tbl.push_back(mk(0,1, 1, 2, 1,1, 3,1,0,0,0, 0,0,0,0, 2'd0, 32'd0)); // add r3
    tbl.push_back(mk(0,1, 3, 1, 1,1, 4,1,0,0,0, 1,0,1,0, 2'd1, 32'd1)); // sub uses r3 (EX)
    tbl.push_back(mk(0,1, 3, 1, 1,1, 4,1,0,0,0, 1,0,1,0, 2'd1, 32'd2)); // r3 now in MEM
    tbl.push_back(mk(0,1, 3, 1, 1,1, 4,1,0,0,0, 0,0,0,0, 2'd0, 32'd2)); // r3 in WB: go
    tbl.push_back(mk(0,1, 1, 2, 1,1, 0,1,0,0,0, 0,0,0,0, 2'd0, 32'd2)); // write r0
    tbl.push_back(mk(0,1, 0, 4, 1,0, 0,0,0,0,0, 0,0,0,0, 2'd0, 32'd2)); // read r0, rt unused
    tbl.push_back(mk(0,1, 1, 0, 1,0, 5,1,1,0,0, 0,0,0,0, 2'd0, 32'd2)); // load r5
    tbl.push_back(mk(0,1, 5, 0, 1,0, 6,1,0,1,0, 0,1,1,0, 2'd2, 32'd2)); // use r5 + branch
    tbl.push_back(mk(0,1, 5, 0, 1,0, 6,1,0,0,0, 1,0,1,0, 2'd1, 32'd3)); // r5 in MEM
    tbl.push_back(mk(0,1, 5, 0, 1,0, 6,1,0,0,1, 1,0,0,1, 2'd3, 32'd4)); // mem_busy
    tbl.push_back(mk(0,1, 5, 0, 1,0, 6,1,0,0,0, 0,0,0,0, 2'd0, 32'd4)); // r5 in WB: go
    tbl.push_back(mk(0,0, 6, 0, 1,0, 7,1,0,0,0, 0,0,0,0, 2'd0, 32'd4)); // id_valid=0
    tbl.push_back(mk(0,1, 0, 6, 0,1, 7,1,0,0,0, 1,0,1,0, 2'd1, 32'd5)); // r6 via rt (MEM)
    tbl.push_back(mk(0,1, 0, 6, 0,1, 7,1,0,1,0, 0,1,1,0, 2'd2, 32'd5)); // branch only
`else
    tbl.push_back(rst_vec());
    tbl.push_back(mk(0,1, 1, 2, 1,1, 3,1,0,0,0, 0,0,0,0, 2'd0, 32'd0)); // add r3
    tbl.push_back(mk(0,1, 3, 1, 1,1, 4,1,0,0,0, 0,0,0,0, 2'd0, 32'd0)); // sub r3: forwarded
    tbl.push_back(mk(0,1, 1, 0, 1,0, 5,1,1,0,0, 0,0,0,0, 2'd0, 32'd0)); // load r5
    tbl.push_back(mk(0,1, 5, 0, 1,0, 6,1,0,0,0, 1,0,1,0, 2'd1, 32'd1)); // load-use
    tbl.push_back(mk(0,1, 5, 0, 1,0, 6,1,0,0,0, 0,0,0,0, 2'd0, 32'd1)); // resolved
    tbl.push_back(mk(0,1, 1, 0, 1,0, 7,1,1,0,0, 0,0,0,0, 2'd0, 32'd1)); // load r7
    tbl.push_back(mk(0,1, 0, 7, 0,1, 8,1,0,1,0, 0,1,1,0, 2'd2, 32'd1)); // use r7 + branch
`endif
    run(tbl, 0);

    // mem_busy held 3 cycles over a pending load-use, then the stall resumes.
    seq.delete();
    seq.push_back(rst_vec());
    seq.push_back(mk(0,1, 1, 0, 1,0, 7,1,1,0,0, 0,0,0,0, 2'd0, 32'd0)); // load r7
    seq.push_back(mk(0,1, 7, 0, 1,0, 9,1,0,0,1, 1,0,0,1, 2'd3, 32'd1));
    seq.push_back(mk(0,1, 7, 0, 1,0, 9,1,0,0,1, 1,0,0,1, 2'd3, 32'd2));
    seq.push_back(mk(0,1, 7, 0, 1,0, 9,1,0,0,1, 1,0,0,1, 2'd3, 32'd3));
    seq.push_back(mk(0,1, 7, 0, 1,0, 9,1,0,0,0, 1,0,1,0, 2'd1, 32'd4)); // r7 still in EX
`ifndef HAZARD_FORWARD_EN
    seq.push_back(mk(0,1, 7, 0, 1,0, 9,1,0,0,0, 1,0,1,0, 2'd1, 32'd5)); // r7 in MEM
    seq.push_back(mk(0,1, 7, 0, 1,0, 9,1,0,0,0, 0,0,0,0, 2'd0, 32'd5));
`else
    seq.push_back(mk(0,1, 7, 0, 1,0, 9,1,0,0,0, 0,0,0,0, 2'd0, 32'd4));
`endif
    run(seq, 100);

    // Reset in the middle of a RAW stall aborts it; scoreboard starts empty.
    seq.delete();
    seq.push_back(rst_vec());
    seq.push_back(mk(0,1, 1, 0, 1,0, 8,1,1,0,0, 0,0,0,0, 2'd0, 32'd0)); // load r8
    seq.push_back(mk(0,1, 8, 0, 1,0, 9,1,0,0,0, 1,0,1,0, 2'd1, 32'd1)); // stall
    seq.push_back(mk(1,1, 8, 0, 1,0, 9,1,0,0,0, 0,0,1,0, 2'd0, 32'd0)); // rst mid-stall
    seq.push_back(mk(0,1, 8, 0, 1,0, 9,1,0,0,0, 0,0,0,0, 2'd0, 32'd0)); // no stall
    run(seq, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
